// File: rtl/branch_target_buffer_pkg.sv
// Shared types and helpers for the branch target buffer.
// Holds the counter-width default, the entry record, and the counter seed functions.
// Entry fields are sized to the largest supported widths; instances zero-extend into them.
package branch_target_buffer_pkg;

    localparam int BTB_CTR_BITS_DEFAULT = 2;
    localparam int BTB_ADDR_W_MAX       = 64;   // widest ADDR_W an instance may use
    localparam int BTB_CTR_W_MAX        = 4;    // widest CTR_BITS an instance may use

    typedef logic [BTB_CTR_W_MAX-1:0] ctr_t;

    typedef struct packed {
        logic                      valid;
        logic [BTB_ADDR_W_MAX-1:0] pc;
        logic [BTB_ADDR_W_MAX-1:0] target;
        ctr_t                      ctr;
    } btb_entry_t;

    // Seed value for a newly allocated taken branch: the lowest value with the MSB set.
    function automatic ctr_t ctr_weak_taken(input int ctr_bits);
        return ctr_t'(1) << (ctr_bits - 1);
    endfunction

    // Seed value for a newly allocated not-taken branch: the highest value with the MSB clear.
    function automatic ctr_t ctr_weak_not_taken(input int ctr_bits);
        return ctr_weak_taken(ctr_bits) - ctr_t'(1);
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up/down prediction counter (next-value logic only).
// Latency: combinational.  Backpressure: none.
// Ports: ctr (current value), dir (1 = count up), en (0 = hold), ctr_nxt (next value).
module sat_counter
    import branch_target_buffer_pkg::*;
#(
    parameter int CTR_BITS = BTB_CTR_BITS_DEFAULT
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                dir,
    input  logic                en,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    always_comb begin
        ctr_nxt = ctr;
        if (en) begin
            if (dir) begin
                if (ctr != CTR_MAX) ctr_nxt = ctr + 1'b1;
            end else begin
                if (ctr != '0) ctr_nxt = ctr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Latency: lookup combinational; update written at the clock edge, visible next cycle (no bypass).
// Backpressure: none; one lookup and one update accepted every cycle.
// Ports: clk/rst (sync active-high); lookup_valid/lookup_pc -> lookup_hit, pred_taken,
//        pred_target, pred_index; update_valid/update_index/update_pc/update_target/update_taken.
// Optional macro BTB_GHR_EN: XORs an IDX_W-bit global taken history into the lookup index.
// ADDR_W may be at most BTB_ADDR_W_MAX and CTR_BITS at most BTB_CTR_W_MAX.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES  = 8,
    parameter int ADDR_W   = 32,
    parameter int CTR_BITS = BTB_CTR_BITS_DEFAULT,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [IDX_W-1:0]  pred_index,
    input  logic              update_valid,
    input  logic [IDX_W-1:0]  update_index,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_taken
);

    btb_entry_t tbl_q [ENTRIES];
    btb_entry_t entry_d;
    btb_entry_t upd_entry;
    logic [IDX_W-1:0] lookup_idx;
    logic upd_hit;
    logic [CTR_BITS-1:0] ctr_nxt;

    // ---------------- lookup index ----------------
`ifdef BTB_GHR_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    assign lookup_idx = lookup_pc[IDX_W+1:2] ^ ghr_q;
    // Shift written as a shift-and-or so a 1-bit history still elaborates cleanly.
    assign ghr_d      = (ghr_q << 1) | IDX_W'(update_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (update_valid) begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign lookup_idx = lookup_pc[IDX_W+1:2];
`endif

    // ---------------- lookup (combinational, reads pre-update state) ----------------
    // rst gates the hit so outputs are quiet even before the first reset edge has cleared valids.
    assign lookup_hit  = lookup_valid && !rst && tbl_q[lookup_idx].valid
                         && (tbl_q[lookup_idx].pc == BTB_ADDR_W_MAX'(lookup_pc));
    assign pred_taken  = lookup_hit && tbl_q[lookup_idx].ctr[CTR_BITS-1];
    assign pred_target = lookup_hit ? tbl_q[lookup_idx].target[ADDR_W-1:0] : '0;
    assign pred_index  = lookup_idx;

    // ---------------- update ----------------
    assign upd_entry = tbl_q[update_index];
    assign upd_hit   = upd_entry.valid && (upd_entry.pc == BTB_ADDR_W_MAX'(update_pc));

    sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_ctr (
        .ctr     (upd_entry.ctr[CTR_BITS-1:0]),
        .dir     (update_taken),
        .en      (upd_hit),
        .ctr_nxt (ctr_nxt)
    );

    always_comb begin
        entry_d = upd_entry;
        if (upd_hit) begin
            entry_d.ctr = BTB_CTR_W_MAX'(ctr_nxt);
            // A not-taken outcome carries no useful target, so keep the learned one.
            if (update_taken) entry_d.target = BTB_ADDR_W_MAX'(update_target);
        end else begin
            entry_d.valid  = 1'b1;
            entry_d.pc     = BTB_ADDR_W_MAX'(update_pc);
            entry_d.target = BTB_ADDR_W_MAX'(update_target);
            entry_d.ctr    = update_taken ? ctr_weak_taken(CTR_BITS)
                                          : ctr_weak_not_taken(CTR_BITS);
        end
    end

    // Reset wins over a coincident update; PCs and targets are left as-is since valid gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid <= 1'b0;
                tbl_q[i].ctr   <= '0;
            end
        end else if (update_valid) begin
            tbl_q[update_index] <= entry_d;
        end
    end

endmodule
